rf_wb_scheduler: RTL and testbench
==================================

Name: rf_wb_scheduler

Overview:
- Write-port scheduler and scoreboard for the 32x32 three-port register file (2 async read ports, 1 sync write port, r0 hardwired to zero).
- Arbitrates the single write port among three writeback sources: src0 = ALU, src1 = load unit, src2 = mul/div.
- Tracks registers with pending writes and stalls issue of any instruction that reads or writes such a register.
- Sits between the execute/memory stages and the register file write port.

Parameters:
- DW, 32, data width of writeback data.
- AW, 5, register address width (2^AW registers).
- STARVE_MAX, 4, consecutive lost cycles after which a pending src1/src2 request is forced ahead of src0 (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_valid  in  3  per-source writeback request.
- wb_wa0, wb_wa1, wb_wa2  in  AW each  destination register per source.
- wb_wd0, wb_wd1, wb_wd2  in  DW each  data per source.
- wb_ready  out  3  one-hot grant, combinational; a transfer occurs when wb_valid[i] & wb_ready[i].
- iss_valid  in  1  decode stage presents an instruction.
- iss_ra1, iss_ra2, iss_wa  in  AW each  source and destination registers of the issuing instruction.
- iss_uses_wa  in  1  instruction writes a register.
- iss_stall  out  1  combinational hazard stall.
- rf_we  out  1  registered write enable to the register file.
- rf_wa  out  AW  registered write address.
- rf_wd  out  DW  registered write data.
- busy_vec  out  2^AW  scoreboard state, for debug.

Behaviour:
- Reset (async, rst_n=0): rf_we=0, rf_wa=0, rf_wd=0, busy_vec=0, rr_ptr=src1, starve_cnt=0. wb_ready is 0 for any source that is not valid. Reset mid-operation drops all in-flight grants and pending writes.
- Grant (combinational, at most one bit set):
  - Forced case: if starve_cnt==STARVE_MAX and (valid1 or valid2), grant the valid one of src1/src2 selected by rr_ptr.
  - Otherwise: src0 if valid; else src1/src2 round-robin by rr_ptr (rr_ptr names the preferred source; if only one is valid, it wins).
  - After a src1 or src2 grant, rr_ptr flips to the other source.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when (valid1|valid2) is set and the grant goes to src0.
  - Clears on any src1/src2 grant, or when neither src1 nor src2 is valid.
- Write latency:
  - A grant in cycle N drives rf_we=1, rf_wa, rf_wd in cycle N+1; the RF writes at the end of N+1.
  - No grant in cycle N gives rf_we=0 in N+1; rf_wa and rf_wd hold their last values.
- Writes to r0 are granted (the handshake completes) but produce rf_we=0 in N+1.
- Scoreboard:
  - Set: busy[iss_wa] is set on an accepted issue (iss_valid & !iss_stall & iss_uses_wa & iss_wa!=0).
  - Clear: busy[rf_wa] is cleared on an edge where rf_we=1, so reads from cycle N+2 onward see the written value.
  - If set and clear hit the same register on the same edge, set wins.
  - busy[0] is always 0.
- iss_stall = iss_valid & (busy[iss_ra1] | busy[iss_ra2] | (iss_uses_wa & busy[iss_wa])). The WAW check is included, so at most one pending write exists per register. A reserved register whose write is still in flight keeps the stall asserted through cycle N+1.
- Width rules: addresses compare on the full AW bits. No arithmetic is performed on data.

Test Plan:
- Reset with all inputs idle -> rf_we=0, busy_vec=0, wb_ready=000, iss_stall=0. Assert rst_n=0 mid-transfer -> outputs return to zero immediately, without waiting for a clock edge.
- Single write: wb_valid=010, wa1=7, wd1=0xDEADBEEF in cycle N -> wb_ready=010 in N; rf_we=1, rf_wa=7, rf_wd=0xDEADBEEF in N+1 only.
- Arbitration: all three valid continuously, STARVE_MAX=4 -> src0 granted for 4 cycles, then src1; then src0 for 4 cycles, then src2 (round-robin alternation).
- Scoreboard: issue with iss_wa=5; next cycle issue with iss_ra1=5 -> iss_stall=1 until rf_we=1 with rf_wa=5 has been clocked, then iss_stall=0 one cycle after the write.
- Same-edge set and clear on r9: rf_we=1, rf_wa=9 while a new issue reserves r9 -> busy_vec[9] stays 1.
- r0 handling: issue with iss_wa=0 -> busy_vec[0]=0. Writeback to r0 -> wb_ready granted, rf_we=0 in the following cycle.

Source files
------------

// File: rtl/rf_wb_scheduler_if.sv
// Bus bundle for rf_wb_scheduler.
//   wb_*   : three writeback sources (0 = ALU, 1 = load, 2 = mul/div), valid/ready
//   iss_*  : decode-stage issue query and the resulting hazard stall
//   rf_*   : registered write port toward the register file
//   busy_vec : scoreboard state, for debug
// master = execute/decode side driving requests; slave = the scheduler.
interface rf_wb_scheduler_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [2:0]          wb_valid;
    logic [AW-1:0]       wb_wa0, wb_wa1, wb_wa2;
    logic [DW-1:0]       wb_wd0, wb_wd1, wb_wd2;
    logic [2:0]          wb_ready;
    logic                iss_valid;
    logic [AW-1:0]       iss_ra1, iss_ra2, iss_wa;
    logic                iss_uses_wa;
    logic                iss_stall;
    logic                rf_we;
    logic [AW-1:0]       rf_wa;
    logic [DW-1:0]       rf_wd;
    logic [(1<<AW)-1:0]  busy_vec;

    modport master (
        output wb_valid, wb_wa0, wb_wa1, wb_wa2, wb_wd0, wb_wd1, wb_wd2,
        output iss_valid, iss_ra1, iss_ra2, iss_wa, iss_uses_wa,
        input  wb_ready, iss_stall, rf_we, rf_wa, rf_wd, busy_vec
    );

    modport slave (
        input  wb_valid, wb_wa0, wb_wa1, wb_wa2, wb_wd0, wb_wd1, wb_wd2,
        input  iss_valid, iss_ra1, iss_ra2, iss_wa, iss_uses_wa,
        output wb_ready, iss_stall, rf_we, rf_wa, rf_wd, busy_vec
    );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Write-port scheduler and scoreboard for a 32x32 register file.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rf_wb_scheduler_if.slave (writeback sources, issue query,
//                registered RF write port, busy_vec)
// Arbitration: src0 (ALU) has priority, src1/src2 round-robin between
// themselves; a src1/src2 request that has lost STARVE_MAX cycles to src0
// is forced through. A grant in cycle N becomes an RF write in cycle N+1.
module rf_wb_scheduler #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    rf_wb_scheduler_if.slave bus
);
    localparam int         NREG    = 1 << AW;
    localparam logic [3:0] SMAX    = 4'(STARVE_MAX);
    localparam logic       RR_SRC1 = 1'b0;
    localparam logic       RR_SRC2 = 1'b1;

    logic            rr_ptr;
    logic [3:0]      starve_cnt;
    logic [2:0]      pick12, grant;
    logic            v0, v1, v2, forced;
    logic [AW-1:0]   g_wa;
    logic [DW-1:0]   g_wd;
    logic            rf_we;
    logic [AW-1:0]   rf_wa;
    logic [DW-1:0]   rf_wd;
    logic [NREG-1:0] busy, busy_nxt;
    logic            iss_stall, iss_acc;

    assign v0 = bus.wb_valid[0];
    assign v1 = bus.wb_valid[1];
    assign v2 = bus.wb_valid[2];

    // Grant is gated by rst_n so an asserted reset drops any grant at once.
    always_comb begin
        pick12 = 3'b000;
        if (v1 && v2) pick12 = (rr_ptr == RR_SRC1) ? 3'b010 : 3'b100;
        else if (v1)  pick12 = 3'b010;
        else if (v2)  pick12 = 3'b100;
        forced = (starve_cnt == SMAX) && (v1 || v2);
        if (forced)  grant = pick12;
        else if (v0) grant = 3'b001;
        else         grant = pick12;
        if (!rst_n)  grant = 3'b000;
    end

    always_comb begin
        g_wa = bus.wb_wa0;
        g_wd = bus.wb_wd0;
        if (grant[1]) begin g_wa = bus.wb_wa1; g_wd = bus.wb_wd1; end
        if (grant[2]) begin g_wa = bus.wb_wa2; g_wd = bus.wb_wd2; end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= RR_SRC1;
            starve_cnt <= 4'd0;
        end else begin
            if (grant[1])      rr_ptr <= RR_SRC2;
            else if (grant[2]) rr_ptr <= RR_SRC1;
            if (grant[1] || grant[2] || !(v1 || v2)) starve_cnt <= 4'd0;
            else if (grant[0] && starve_cnt != SMAX) starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Write stage: r0 writes complete the handshake but never reach the RF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= (|grant) && (g_wa != '0);
            if (|grant) begin
                rf_wa <= g_wa;
                rf_wd <= g_wd;
            end
        end
    end

    // Scoreboard: set after clear so a same-edge reservation survives.
    assign iss_stall = bus.iss_valid & (busy[bus.iss_ra1] | busy[bus.iss_ra2] |
                                        (bus.iss_uses_wa & busy[bus.iss_wa]));
    assign iss_acc   = bus.iss_valid & ~iss_stall & bus.iss_uses_wa & (bus.iss_wa != '0);

    always_comb begin
        busy_nxt = busy;
        if (rf_we)   busy_nxt[rf_wa]      = 1'b0;
        if (iss_acc) busy_nxt[bus.iss_wa] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    assign bus.wb_ready  = grant;
    assign bus.iss_stall = iss_stall;
    assign bus.rf_we     = rf_we;
    assign bus.rf_wa     = rf_wa;
    assign bus.rf_wd     = rf_wd;
    assign bus.busy_vec  = busy;
endmodule

// File: tb/tb_rf_wb_scheduler.sv
module tb_rf_wb_scheduler;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NV = 22;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ntests = 0;
    int   nfail = 0;
    logic mon_en = 1'b0;

    rf_wb_scheduler_if #(.DW(DW), .AW(AW)) bus ();

    rf_wb_scheduler #(.DW(DW), .AW(AW), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    v;
        logic [AW-1:0] wa0, wa1, wa2;
        logic [DW-1:0] wd0, wd1, wd2;
        logic [2:0]    exp_rdy;
    } vec_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wr_t;

    vec_t tbl [NV];
    wr_t  q [$];

    localparam logic [2:0] VS [NV] = '{
        3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
        3'b010, 3'b000, 3'b001, 3'b110, 3'b110, 3'b101, 3'b001,
        3'b101, 3'b101, 3'b101, 3'b101, 3'b101};
    localparam logic [2:0] ER [NV] = '{
        3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001, 3'b100,
        3'b010, 3'b000, 3'b001, 3'b100, 3'b010, 3'b001, 3'b001,
        3'b001, 3'b001, 3'b001, 3'b001, 3'b100};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each cycle pop last cycle's expected write, then push this cycle's.
    always @(negedge clk) begin
        #3;
        if (mon_en) begin
            wr_t e;
            wr_t n;
            if (q.size() > 0) e = q.pop_front();
            else begin e.we = 1'b0; e.wa = '0; e.wd = '0; end
            chk("rf_we", 64'(bus.rf_we), 64'(e.we));
            if (e.we) begin
                chk("rf_wa", 64'(bus.rf_wa), 64'(e.wa));
                chk("rf_wd", 64'(bus.rf_wd), 64'(e.wd));
            end
            chk("rdy_onehot_valid", 64'($countones(bus.wb_ready) <= 1 &&
                ((bus.wb_ready & ~bus.wb_valid) == 3'b000)), 64'(1));
            n.we = 1'b0; n.wa = '0; n.wd = '0;
            if (bus.wb_valid[0] & bus.wb_ready[0]) begin n.wa = bus.wb_wa0; n.wd = bus.wb_wd0; end
            if (bus.wb_valid[1] & bus.wb_ready[1]) begin n.wa = bus.wb_wa1; n.wd = bus.wb_wd1; end
            if (bus.wb_valid[2] & bus.wb_ready[2]) begin n.wa = bus.wb_wa2; n.wd = bus.wb_wd2; end
            n.we = |(bus.wb_valid & bus.wb_ready) && (n.wa != '0);
            q.push_back(n);
        end else begin
            q.delete();
        end
    end

    initial begin
        bus.wb_valid = 3'b000;
        bus.wb_wa0 = '0; bus.wb_wa1 = '0; bus.wb_wa2 = '0;
        bus.wb_wd0 = '0; bus.wb_wd1 = '0; bus.wb_wd2 = '0;
        bus.iss_valid = 1'b0; bus.iss_ra1 = '0; bus.iss_ra2 = '0;
        bus.iss_wa = '0; bus.iss_uses_wa = 1'b0;

        for (int i = 0; i < NV; i++) begin
            tbl[i].v       = VS[i];
            tbl[i].exp_rdy = ER[i];
            tbl[i].wa0     = AW'(1 + (i % 30));
            tbl[i].wa1     = AW'(2 + (i % 29));
            tbl[i].wa2     = AW'(3 + (i % 28));
            tbl[i].wd0     = $urandom;
            tbl[i].wd1     = $urandom;
            tbl[i].wd2     = $urandom;
        end
        tbl[10].wa1 = AW'(7);
        tbl[10].wd1 = 32'hDEADBEEF;
        tbl[12].wa0 = '0;

        // Reset state with idle inputs
        #12;
        chk("rst_rf_we", 64'(bus.rf_we), 64'(0));
        chk("rst_busy", 64'(bus.busy_vec), 64'(0));
        chk("rst_ready", 64'(bus.wb_ready), 64'(0));
        chk("rst_stall", 64'(bus.iss_stall), 64'(0));
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Arbitration / single write / r0 writeback table
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.wb_valid = tbl[i].v;
            bus.wb_wa0 = tbl[i].wa0; bus.wb_wa1 = tbl[i].wa1; bus.wb_wa2 = tbl[i].wa2;
            bus.wb_wd0 = tbl[i].wd0; bus.wb_wd1 = tbl[i].wd1; bus.wb_wd2 = tbl[i].wd2;
            #2;
            chk($sformatf("grant[%0d]", i), 64'(bus.wb_ready), 64'(tbl[i].exp_rdy));
        end
        @(negedge clk);
        bus.wb_valid = 3'b000;

        // RAW hazard on r5 held until its write has been clocked
        @(negedge clk);
        bus.iss_valid = 1'b1; bus.iss_wa = AW'(5); bus.iss_uses_wa = 1'b1;
        bus.iss_ra1 = '0; bus.iss_ra2 = '0;
        #2 chk("sb_issue_stall", 64'(bus.iss_stall), 64'(0));
        @(negedge clk);
        bus.iss_ra1 = AW'(5); bus.iss_wa = '0; bus.iss_uses_wa = 1'b0;
        #2 chk("sb_busy5", 64'(bus.busy_vec[5]), 64'(1));
        chk("sb_raw_stall0", 64'(bus.iss_stall), 64'(1));
        @(negedge clk);
        #2 chk("sb_raw_stall1", 64'(bus.iss_stall), 64'(1));
        @(negedge clk);
        bus.wb_valid = 3'b001; bus.wb_wa0 = AW'(5); bus.wb_wd0 = 32'h5555AAAA;
        #2 chk("sb_wb_grant", 64'(bus.wb_ready), 64'(3'b001));
        chk("sb_raw_stall2", 64'(bus.iss_stall), 64'(1));
        @(negedge clk);
        bus.wb_valid = 3'b000;
        #2 chk("sb_inflight_stall", 64'(bus.iss_stall), 64'(1));
        chk("sb_inflight_wa", 64'(bus.rf_wa), 64'(5));
        @(negedge clk);
        #2 chk("sb_release_stall", 64'(bus.iss_stall), 64'(0));
        chk("sb_busy5_clr", 64'(bus.busy_vec[5]), 64'(0));
        bus.iss_valid = 1'b0; bus.iss_ra1 = '0;

        // Same-edge clear and set on r9: set wins
        @(negedge clk);
        bus.wb_valid = 3'b001; bus.wb_wa0 = AW'(9); bus.wb_wd0 = 32'h00000009;
        @(negedge clk);
        bus.wb_valid = 3'b000;
        bus.iss_valid = 1'b1; bus.iss_wa = AW'(9); bus.iss_uses_wa = 1'b1;
        #2 chk("r9_stall", 64'(bus.iss_stall), 64'(0));
        chk("r9_rf_we", 64'(bus.rf_we), 64'(1));
        chk("r9_rf_wa", 64'(bus.rf_wa), 64'(9));
        @(negedge clk);
        bus.iss_valid = 1'b0;
        #2 chk("r9_busy", 64'(bus.busy_vec[9]), 64'(1));

        // Issue targeting r0 never reserves it
        @(negedge clk);
        bus.iss_valid = 1'b1; bus.iss_wa = '0; bus.iss_uses_wa = 1'b1;
        #2 chk("r0_issue_stall", 64'(bus.iss_stall), 64'(0));
        @(negedge clk);
        bus.iss_valid = 1'b0; bus.iss_uses_wa = 1'b0;
        #2 chk("r0_busy0", 64'(bus.busy_vec[0]), 64'(0));
        chk("busy_vec_r9only", 64'(bus.busy_vec), 64'(32'h0000_0200));

        // Asynchronous reset in the middle of a transfer
        @(negedge clk);
        bus.wb_valid = 3'b111;
        bus.wb_wa0 = AW'(3); bus.wb_wa1 = AW'(3); bus.wb_wa2 = AW'(3);
        bus.iss_valid = 1'b1; bus.iss_wa = AW'(4); bus.iss_uses_wa = 1'b1;
        @(negedge clk);
        mon_en = 1'b0;
        bus.iss_ra1 = AW'(4); bus.iss_wa = '0; bus.iss_uses_wa = 1'b0;
        #2 chk("mid_pre_we", 64'(bus.rf_we), 64'(1));
        chk("mid_pre_wa", 64'(bus.rf_wa), 64'(3));
        chk("mid_pre_stall", 64'(bus.iss_stall), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 64'(bus.rf_we), 64'(0));
        chk("mid_rst_wa", 64'(bus.rf_wa), 64'(0));
        chk("mid_rst_wd", 64'(bus.rf_wd), 64'(0));
        chk("mid_rst_busy", 64'(bus.busy_vec), 64'(0));
        chk("mid_rst_ready", 64'(bus.wb_ready), 64'(0));
        chk("mid_rst_stall", 64'(bus.iss_stall), 64'(0));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
